// File: rtl/j1_io_bus_pkg.sv
// Shared I/O map for the J1 SoC: peripheral page numbers, default slot table and status offsets.
package j1_io_bus_pkg;

   localparam logic [7:0] PAGE_MULT  = 8'h65;
   localparam logic [7:0] PAGE_DIV   = 8'h66;
   localparam logic [7:0] PAGE_UART  = 8'h67;
   localparam logic [7:0] PAGE_BT    = 8'h68;
   localparam logic [7:0] PAGE_AUDIO = 8'h69;
   localparam logic [7:0] PAGE_DPRAM = 8'h70;
   localparam logic [7:0] PAGE_STAT  = 8'h71;

   localparam logic [47:0] DEFAULT_SLOT_BASE =
      {PAGE_DPRAM, PAGE_AUDIO, PAGE_BT, PAGE_UART, PAGE_DIV, PAGE_MULT};

   localparam logic [15:0] DEFAULT_RD = 16'h0666;

   typedef enum logic [1:0] {
      STAT_OFS_CNT  = 2'd0,
      STAT_OFS_ADDR = 2'd1,
      STAT_OFS_INFO = 2'd2,
      STAT_OFS_ID   = 2'd3
   } stat_ofs_e;

endpackage

// File: rtl/j1_io_bus_errlog.sv
// Unmapped-access logger: saturating counter, address/type capture, sticky flag, pulse
// and the read mux for the built-in status page.
module j1_io_bus_errlog
   import j1_io_bus_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int NSLOT = 6
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_rd,
   input  logic        i_wr,
   input  logic [15:0] i_addr,
   input  logic        i_unmapped,
   input  logic        i_stat_sel,
   output logic [15:0] o_stat_rdata,
   output logic        o_err_flag,
   output logic        o_err_pulse
);

   logic [CNT_W-1:0] r_err_cnt;
   logic [15:0]      r_bad_addr;
   logic [1:0]       r_bad_type;
   logic             r_err_flag;
   logic             r_err_pulse;
   stat_ofs_e        w_ofs;

   assign w_ofs = stat_ofs_e'(i_addr[1:0]);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_err_cnt   <= '0;
         r_bad_addr  <= '0;
         r_bad_type  <= '0;
         r_err_flag  <= 1'b0;
         r_err_pulse <= 1'b0;
      end else begin
         r_err_pulse <= 1'b0;
         if (i_unmapped) begin
            if (r_err_cnt != {CNT_W{1'b1}})
               r_err_cnt <= r_err_cnt + CNT_W'(1);
            r_bad_addr  <= i_addr;
            r_bad_type  <= {i_wr, i_rd};
            r_err_flag  <= 1'b1;
            r_err_pulse <= 1'b1;
         end else if (i_stat_sel && i_wr) begin
            // offset 0 clears the count/flag, offset 3 clears the capture; 1 and 2 are read-only
            case (w_ofs)
               STAT_OFS_CNT: begin
                  r_err_cnt  <= '0;
                  r_err_flag <= 1'b0;
               end
               STAT_OFS_ID: begin
                  r_bad_addr <= '0;
                  r_bad_type <= '0;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      o_stat_rdata = 16'h0000;
      case (w_ofs)
         STAT_OFS_CNT:  o_stat_rdata = 16'(r_err_cnt);
         STAT_OFS_ADDR: o_stat_rdata = r_bad_addr;
         STAT_OFS_INFO: o_stat_rdata = {13'b0, r_err_flag, r_bad_type};
         STAT_OFS_ID:   o_stat_rdata = 16'(NSLOT);
         default:       o_stat_rdata = 16'h0000;
      endcase
   end

   assign o_err_flag  = r_err_flag;
   assign o_err_pulse = r_err_pulse;

endmodule

// File: rtl/j1_io_bus.sv
// J1 I/O interconnect: page decode to one-hot chip selects, read-data mux and the
// unmapped-access status page.
module j1_io_bus
   import j1_io_bus_pkg::*;
#(
   parameter int                 NSLOT      = 6,
   parameter logic [NSLOT*8-1:0] SLOT_BASE  = DEFAULT_SLOT_BASE,
   parameter logic [7:0]         STAT_PAGE  = PAGE_STAT,
   parameter bit                 READ_REG   = 1'b0,
   parameter logic [15:0]        DEF_RD     = DEFAULT_RD,
   parameter int                 CNT_W      = 8
) (
   input  logic                  sys_clk_i,
   input  logic                  sys_rst_i,
   input  logic                  io_rd,
   input  logic                  io_wr,
   input  logic [15:0]           io_addr,
   input  logic [15:0]           io_dout,
   output logic [15:0]           io_din,
   output logic [NSLOT-1:0]      cs,
   input  logic [NSLOT*16-1:0]   slot_dout,
   output logic                  err_flag,
   output logic                  err_pulse
);

   logic [NSLOT-1:0] w_hit;
   logic [NSLOT-1:0] w_cs;
   logic             w_any_hit;
   logic [15:0]      w_slot_rd;
   logic [15:0]      w_stat_rd;
   logic [15:0]      w_rd_mux;
   logic             w_stat_sel;
   logic             w_unmapped;
   logic             w_unused_dout;

   // status-page writes only use the offset, never the data
   assign w_unused_dout = ^io_dout;

   genvar g;
   generate
      for (g = 0; g < NSLOT; g++) begin : g_hit
         assign w_hit[g] = (io_addr[15:8] == SLOT_BASE[8*g +: 8]);
      end
   endgenerate

   // lowest-index hit wins when two slots share a base
   always_comb begin
      w_cs      = '0;
      w_any_hit = 1'b0;
      w_slot_rd = 16'h0000;
      for (int i = 0; i < NSLOT; i++) begin
         if (w_hit[i] && !w_any_hit) begin
            w_cs[i]   = 1'b1;
            w_any_hit = 1'b1;
            w_slot_rd = slot_dout[16*i +: 16];
         end
      end
   end

   assign w_stat_sel = !w_any_hit && (io_addr[15:8] == STAT_PAGE);
   assign w_unmapped = (io_rd || io_wr) && !w_any_hit && !w_stat_sel;
   assign w_rd_mux   = w_any_hit ? w_slot_rd : (w_stat_sel ? w_stat_rd : DEF_RD);
   assign cs         = w_cs;

   j1_io_bus_errlog #(
      .CNT_W (CNT_W),
      .NSLOT (NSLOT)
   ) u_errlog (
      .i_clk        (sys_clk_i),
      .i_rst        (sys_rst_i),
      .i_rd         (io_rd),
      .i_wr         (io_wr),
      .i_addr       (io_addr),
      .i_unmapped   (w_unmapped),
      .i_stat_sel   (w_stat_sel),
      .o_stat_rdata (w_stat_rd),
      .o_err_flag   (err_flag),
      .o_err_pulse  (err_pulse)
   );

   generate
      if (READ_REG) begin : g_rd_reg
         logic [15:0] r_din;
         always_ff @(posedge sys_clk_i) begin
            if (sys_rst_i)
               r_din <= DEF_RD;
            else if (io_rd)
               r_din <= w_rd_mux;
         end
         assign io_din = r_din;
      end else begin : g_rd_comb
         assign io_din = w_rd_mux;
      end
   endgenerate

endmodule

// File: tb/tb_j1_io_bus.sv
// Directed bench: one combinational-read instance with the default map and one
// registered-read instance whose slots 1 and 4 share page 0x68.
module tb_j1_io_bus;

   logic         sys_clk_i = 1'b0;
   logic         sys_rst_i = 1'b1;
   logic         io_rd     = 1'b0;
   logic         io_wr     = 1'b1;
   logic [15:0]  io_addr   = 16'h5000;
   logic [15:0]  io_dout   = 16'h0000;
   logic [95:0]  slot_dout = {16'h5555, 16'h4444, 16'h3333, 16'h1234, 16'h1111, 16'h0000};

   logic [15:0]  c_din, r_din;
   logic [5:0]   c_cs, r_cs;
   logic         c_flag, c_pulse, r_flag, r_pulse;

   int checks = 0;
   int errors = 0;

   always #5 sys_clk_i = ~sys_clk_i;

   j1_io_bus #(.READ_REG(1'b0)) dut_c (
      .sys_clk_i (sys_clk_i), .sys_rst_i (sys_rst_i), .io_rd (io_rd), .io_wr (io_wr),
      .io_addr (io_addr), .io_dout (io_dout), .io_din (c_din), .cs (c_cs),
      .slot_dout (slot_dout), .err_flag (c_flag), .err_pulse (c_pulse)
   );

   // slot0=65 slot1=68 slot2=67 slot3=66 slot4=68 slot5=70; page 69 unmapped here
   j1_io_bus #(.READ_REG(1'b1),
               .SLOT_BASE({8'h70, 8'h68, 8'h66, 8'h67, 8'h68, 8'h65})) dut_r (
      .sys_clk_i (sys_clk_i), .sys_rst_i (sys_rst_i), .io_rd (io_rd), .io_wr (io_wr),
      .io_addr (io_addr), .io_dout (io_dout), .io_din (r_din), .cs (r_cs),
      .slot_dout (slot_dout), .err_flag (r_flag), .err_pulse (r_pulse)
   );

   task automatic tick();
      @(posedge sys_clk_i);
      #1;
   endtask

   task automatic bus(input logic rd, input logic wr, input logic [15:0] addr);
      tick();
      io_rd   = rd;
      io_wr   = wr;
      io_addr = addr;
      io_dout = 16'hBEEF;
   endtask

   task automatic test_reset();
      tick(); tick(); tick();
      checks++; if (c_pulse !== 1'b0) begin errors++; $display("FAIL rst_pulse got %b exp 0", c_pulse); end
      checks++; if (c_flag !== 1'b0) begin errors++; $display("FAIL rst_flag got %b exp 0", c_flag); end
      checks++; if (r_din !== 16'h0666) begin errors++; $display("FAIL rst_r_din got %h exp 0666", r_din); end
      checks++; if (c_din !== 16'h0666) begin errors++; $display("FAIL rst_c_din_unmapped got %h exp 0666", c_din); end
      sys_rst_i = 1'b0;
      io_wr     = 1'b0;
      io_addr   = 16'h0000;
      bus(1'b1, 1'b0, 16'h7100);
      #3;
      checks++; if (c_din !== 16'h0000) begin errors++; $display("FAIL rst_cnt got %h exp 0000", c_din); end
      tick();
      checks++; if (r_din !== 16'h0000) begin errors++; $display("FAIL rst_r_cnt got %h exp 0000", r_din); end
      checks++; if (c_pulse !== 1'b0) begin errors++; $display("FAIL rst_no_err got %b exp 0", c_pulse); end
   endtask

   task automatic test_slot_read();
      bus(1'b1, 1'b0, 16'h6700);
      #3;
      checks++; if (c_cs !== 6'b000100) begin errors++; $display("FAIL slot_c_cs got %b exp 000100", c_cs); end
      checks++; if (c_din !== 16'h1234) begin errors++; $display("FAIL slot_c_din got %h exp 1234", c_din); end
      checks++; if (r_cs !== 6'b000100) begin errors++; $display("FAIL slot_r_cs got %b exp 000100", r_cs); end
      checks++; if (r_din !== 16'h0000) begin errors++; $display("FAIL slot_r_din_early got %h exp 0000", r_din); end
      tick();
      checks++; if (r_din !== 16'h1234) begin errors++; $display("FAIL slot_r_din got %h exp 1234", r_din); end
      bus(1'b0, 1'b0, 16'h6600);
      #3;
      checks++; if (c_cs !== 6'b000010) begin errors++; $display("FAIL cs_no_strobe_c got %b exp 000010", c_cs); end
      checks++; if (r_cs !== 6'b001000) begin errors++; $display("FAIL cs_no_strobe_r got %b exp 001000", r_cs); end
      bus(1'b1, 1'b0, 16'h70AB);
      #3;
      checks++; if (c_din !== 16'h5555) begin errors++; $display("FAIL slot5_c_din got %h exp 5555", c_din); end
      tick();
      checks++; if (r_din !== 16'h5555) begin errors++; $display("FAIL slot5_r_din got %h exp 5555", r_din); end
      checks++; if (c_flag !== 1'b0) begin errors++; $display("FAIL slot_no_flag got %b exp 0", c_flag); end
   endtask

   task automatic test_unmapped();
      bus(1'b1, 1'b0, 16'h5000);
      #3;
      checks++; if (c_cs !== 6'b000000) begin errors++; $display("FAIL unm_cs got %b exp 000000", c_cs); end
      checks++; if (c_din !== 16'h0666) begin errors++; $display("FAIL unm_din got %h exp 0666", c_din); end
      checks++; if (c_pulse !== 1'b0) begin errors++; $display("FAIL unm_pulse_early got %b exp 0", c_pulse); end
      bus(1'b0, 1'b0, 16'h0000);
      checks++; if (c_pulse !== 1'b1) begin errors++; $display("FAIL unm_pulse got %b exp 1", c_pulse); end
      checks++; if (c_flag !== 1'b1) begin errors++; $display("FAIL unm_flag got %b exp 1", c_flag); end
      checks++; if (r_pulse !== 1'b1) begin errors++; $display("FAIL unm_r_pulse got %b exp 1", r_pulse); end
      checks++; if (r_din !== 16'h0666) begin errors++; $display("FAIL unm_r_din got %h exp 0666", r_din); end
      tick();
      checks++; if (c_pulse !== 1'b0) begin errors++; $display("FAIL unm_pulse_len got %b exp 0", c_pulse); end
      bus(1'b1, 1'b0, 16'h7100); #3;
      checks++; if (c_din !== 16'h0001) begin errors++; $display("FAIL unm_cnt got %h exp 0001", c_din); end
      bus(1'b1, 1'b0, 16'h7101); #3;
      checks++; if (c_din !== 16'h5000) begin errors++; $display("FAIL unm_addr got %h exp 5000", c_din); end
      bus(1'b1, 1'b0, 16'h7102); #3;
      checks++; if (c_din !== 16'h0005) begin errors++; $display("FAIL unm_info got %h exp 0005", c_din); end
      bus(1'b1, 1'b0, 16'h7103); #3;
      checks++; if (c_din !== 16'h0006) begin errors++; $display("FAIL unm_nslot got %h exp 0006", c_din); end
      tick();
      checks++; if (c_pulse !== 1'b0) begin errors++; $display("FAIL stat_rd_no_err got %b exp 0", c_pulse); end
      checks++; if (r_din !== 16'h0006) begin errors++; $display("FAIL unm_r_nslot got %h exp 0006", r_din); end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 300; i++) bus(1'b0, 1'b1, 16'h4000 + 16'(i));
      bus(1'b0, 1'b0, 16'h0000);
      checks++; if (c_pulse !== 1'b1) begin errors++; $display("FAIL sat_pulse got %b exp 1", c_pulse); end
      bus(1'b1, 1'b0, 16'h7100); #3;
      checks++; if (c_din !== 16'h00FF) begin errors++; $display("FAIL sat_cnt got %h exp 00ff", c_din); end
      bus(1'b1, 1'b0, 16'h7101); #3;
      checks++; if (c_din !== 16'h412B) begin errors++; $display("FAIL sat_addr got %h exp 412b", c_din); end
      bus(1'b1, 1'b0, 16'h7102); #3;
      checks++; if (c_din !== 16'h0006) begin errors++; $display("FAIL sat_info got %h exp 0006", c_din); end
   endtask

   task automatic test_clear();
      bus(1'b0, 1'b1, 16'h7100);
      bus(1'b1, 1'b0, 16'h7100); #3;
      checks++; if (c_din !== 16'h0000) begin errors++; $display("FAIL clr_cnt got %h exp 0000", c_din); end
      checks++; if (c_flag !== 1'b0) begin errors++; $display("FAIL clr_flag got %b exp 0", c_flag); end
      checks++; if (c_pulse !== 1'b0) begin errors++; $display("FAIL clr_no_pulse got %b exp 0", c_pulse); end
      bus(1'b1, 1'b0, 16'h7101); #3;
      checks++; if (c_din !== 16'h412B) begin errors++; $display("FAIL clr_addr_kept got %h exp 412b", c_din); end
      bus(1'b1, 1'b0, 16'h7102); #3;
      checks++; if (c_din !== 16'h0002) begin errors++; $display("FAIL clr_info got %h exp 0002", c_din); end
      bus(1'b0, 1'b1, 16'h7101);
      bus(1'b0, 1'b1, 16'h7102);
      bus(1'b1, 1'b0, 16'h7101); #3;
      checks++; if (c_din !== 16'h412B) begin errors++; $display("FAIL ro_addr got %h exp 412b", c_din); end
      bus(1'b0, 1'b1, 16'h7103);
      bus(1'b1, 1'b0, 16'h7101); #3;
      checks++; if (c_din !== 16'h0000) begin errors++; $display("FAIL clr3_addr got %h exp 0000", c_din); end
      bus(1'b1, 1'b0, 16'h7102); #3;
      checks++; if (c_din !== 16'h0000) begin errors++; $display("FAIL clr3_info got %h exp 0000", c_din); end
   endtask

   task automatic test_dup_base();
      bus(1'b1, 1'b0, 16'h6812);
      #3;
      checks++; if (r_cs !== 6'b000010) begin errors++; $display("FAIL dup_r_cs got %b exp 000010", r_cs); end
      checks++; if (c_cs !== 6'b001000) begin errors++; $display("FAIL dup_c_cs got %b exp 001000", c_cs); end
      checks++; if (c_din !== 16'h3333) begin errors++; $display("FAIL dup_c_din got %h exp 3333", c_din); end
      tick();
      checks++; if (r_din !== 16'h1111) begin errors++; $display("FAIL dup_r_din got %h exp 1111", r_din); end
      bus(1'b1, 1'b0, 16'h6900);
      bus(1'b0, 1'b0, 16'h0000);
      checks++; if (r_pulse !== 1'b1) begin errors++; $display("FAIL p69_r_pulse got %b exp 1", r_pulse); end
      checks++; if (c_pulse !== 1'b0) begin errors++; $display("FAIL p69_c_pulse got %b exp 0", c_pulse); end
      checks++; if (r_din !== 16'h0666) begin errors++; $display("FAIL p69_r_din got %h exp 0666", r_din); end
   endtask

   task automatic test_both_strobes();
      bus(1'b1, 1'b1, 16'h5555);
      bus(1'b1, 1'b0, 16'h7102); #3;
      checks++; if (c_din !== 16'h0007) begin errors++; $display("FAIL both_info got %h exp 0007", c_din); end
      bus(1'b1, 1'b0, 16'h7100); #3;
      checks++; if (c_din !== 16'h0001) begin errors++; $display("FAIL both_cnt got %h exp 0001", c_din); end
      bus(1'b1, 1'b0, 16'h7101); #3;
      checks++; if (c_din !== 16'h5555) begin errors++; $display("FAIL both_addr got %h exp 5555", c_din); end
   endtask

   task automatic test_read_hold();
      bus(1'b1, 1'b0, 16'h6700);
      bus(1'b0, 1'b0, 16'h6500);
      checks++; if (r_din !== 16'h1234) begin errors++; $display("FAIL hold_load got %h exp 1234", r_din); end
      #3;
      checks++; if (c_din !== 16'h0000) begin errors++; $display("FAIL hold_c_din got %h exp 0000", c_din); end
      tick();
      checks++; if (r_din !== 16'h1234) begin errors++; $display("FAIL hold_r_din got %h exp 1234", r_din); end
   endtask

   task automatic test_reset_mid();
      tick();
      sys_rst_i = 1'b1;
      io_rd     = 1'b0;
      io_wr     = 1'b1;
      io_addr   = 16'h5000;
      tick();
      checks++; if (r_din !== 16'h0666) begin errors++; $display("FAIL mid_r_din got %h exp 0666", r_din); end
      checks++; if (c_flag !== 1'b0) begin errors++; $display("FAIL mid_flag got %b exp 0", c_flag); end
      tick();
      checks++; if (c_pulse !== 1'b0) begin errors++; $display("FAIL mid_pulse got %b exp 0", c_pulse); end
      sys_rst_i = 1'b0;
      io_wr     = 1'b0;
      io_rd     = 1'b1;
      io_addr   = 16'h7100;
      #3;
      checks++; if (c_din !== 16'h0000) begin errors++; $display("FAIL mid_cnt got %h exp 0000", c_din); end
      tick();
      checks++; if (r_din !== 16'h0000) begin errors++; $display("FAIL mid_r_cnt got %h exp 0000", r_din); end
      checks++; if (r_flag !== 1'b0) begin errors++; $display("FAIL mid_r_flag got %b exp 0", r_flag); end
      bus(1'b0, 1'b0, 16'h0000);
   endtask

   initial begin
      test_reset();
      test_slot_read();
      test_unmapped();
      test_saturate();
      test_clear();
      test_dup_base();
      test_both_strobes();
      test_read_hold();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
